// File: rtl/scan_frame_capture.sv
// Receive side of the multiplexed digit scan bus: rebuilds 4-digit frames from
// in-order select/digit strobes and offers them on a valid/ready output slot.
module scan_frame_capture #(
  parameter int DIGIT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 strobe_in,
  input  logic [1:0]           sel_in,
  input  logic [DIGIT_W-1:0]   digit_in,
  input  logic                 frame_ready,
  output logic [4*DIGIT_W-1:0] frame_out,
  output logic                 frame_valid,
  output logic                 seq_err,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           exp_q, exp_d;
  logic [4*DIGIT_W-1:0] shadow_q, shadow_d;
  logic [4*DIGIT_W-1:0] frame_q, frame_d;
  logic                 valid_q, valid_d;
  logic                 seq_err_q, seq_err_d;
  logic [7:0]           drop_q, drop_d;
  logic                 slot_free;

  // Slot is free if empty or being emptied by a transfer on this same edge.
  assign slot_free = ~valid_q | frame_ready;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    shadow_d  = shadow_q;
    frame_d   = frame_q;
    valid_d   = valid_q & ~frame_ready;
    seq_err_d = 1'b0;
    drop_d    = drop_q;

    if (strobe_in) begin
      unique case (state_q)
        SYNC: begin
          if (sel_in == 2'd0) begin
            shadow_d[0 +: DIGIT_W] = digit_in;
            exp_d                  = 2'd1;
            state_d                = COLLECT;
          end
        end
        COLLECT: begin
          if (sel_in == exp_q) begin
            shadow_d[sel_in*DIGIT_W +: DIGIT_W] = digit_in;
            exp_d = exp_q + 2'd1;
            if (sel_in == 2'd3) begin
              // Digit 3 comes straight from the bus so the frame lands on this edge.
              if (slot_free) begin
                frame_d = {digit_in, shadow_q[3*DIGIT_W-1:0]};
                valid_d = 1'b1;
              end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
              end
            end
          end else begin
            seq_err_d = 1'b1;
            if (sel_in == 2'd0) begin
              shadow_d[0 +: DIGIT_W] = digit_in;
              exp_d                  = 2'd1;
            end else begin
              exp_d   = 2'd0;
              state_d = SYNC;
            end
          end
        end
        default: begin
          state_d = SYNC;
          exp_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      exp_q     <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      seq_err_q <= seq_err_d;
      drop_q    <= drop_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign seq_err     = seq_err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_scan_frame_capture.sv
// Directed bench for scan_frame_capture: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_scan_frame_capture;

  localparam int DIGIT_W = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 strobe_in;
  logic [1:0]           sel_in;
  logic [DIGIT_W-1:0]   digit_in;
  logic                 frame_ready;
  logic [4*DIGIT_W-1:0] frame_out;
  logic                 frame_valid;
  logic                 seq_err;
  logic [7:0]           drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  scan_frame_capture #(.DIGIT_W(DIGIT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .strobe_in   (strobe_in),
    .sel_in      (sel_in),
    .digit_in    (digit_in),
    .frame_ready (frame_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .seq_err     (seq_err),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Apply inputs for one clock edge and return at the next falling edge.
  task automatic cyc(input logic s, input logic [1:0] sel, input logic [3:0] dig, input logic rdy);
    strobe_in   = s;
    sel_in      = sel;
    digit_in    = dig;
    frame_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3, input logic rdy);
    cyc(1'b1, 2'd0, d0, rdy);
    cyc(1'b1, 2'd1, d1, rdy);
    cyc(1'b1, 2'd2, d2, rdy);
    cyc(1'b1, 2'd3, d3, rdy);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(1'b0, 2'd0, 4'h0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    strobe_in   = 1'b0;
    sel_in      = 2'd0;
    digit_in    = '0;
    frame_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_frame_out", 32'(frame_out), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_seq_err", 32'(seq_err), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    reset_n = 1'b1;

    // Basic in-order frame
    send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    check("t1_frame", 32'(frame_out), 32'h4321);
    check("t1_valid", 32'(frame_valid), 32'h1);
    check("t1_seq_err", 32'(seq_err), 32'h0);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    check("t1_valid_drop", 32'(frame_valid), 32'h0);

    // Non-zero selects ignored while in SYNC
    do_reset();
    cyc(1'b1, 2'd2, 4'hA, 1'b1);
    check("t2_sync_ign_a", 32'(seq_err), 32'h0);
    cyc(1'b1, 2'd3, 4'hB, 1'b1);
    check("t2_sync_ign_b", 32'(seq_err), 32'h0);
    check("t2_no_valid", 32'(frame_valid), 32'h0);
    send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    check("t2_frame", 32'(frame_out), 32'h4321);
    check("t2_valid", 32'(frame_valid), 32'h1);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    check("t2_valid_drop", 32'(frame_valid), 32'h0);

    // Out-of-order non-zero select -> error, back to SYNC
    cyc(1'b1, 2'd0, 4'h9, 1'b1);
    cyc(1'b1, 2'd1, 4'h9, 1'b1);
    cyc(1'b1, 2'd3, 4'h9, 1'b1);
    check("t3_seq_err", 32'(seq_err), 32'h1);
    check("t3_no_frame", 32'(frame_valid), 32'h0);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    check("t3_seq_err_pulse", 32'(seq_err), 32'h0);
    cyc(1'b1, 2'd1, 4'h9, 1'b1);
    check("t3_in_sync", 32'(seq_err), 32'h0);
    send_frame(4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
    check("t3_frame", 32'(frame_out), 32'h8765);
    check("t3_valid", 32'(frame_valid), 32'h1);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);

    // Unexpected sel 0 restarts the frame
    cyc(1'b1, 2'd0, 4'h1, 1'b1);
    cyc(1'b1, 2'd1, 4'h2, 1'b1);
    cyc(1'b1, 2'd0, 4'hC, 1'b1);
    check("t3b_seq_err", 32'(seq_err), 32'h1);
    cyc(1'b1, 2'd1, 4'hD, 1'b1);
    check("t3b_seq_err_pulse", 32'(seq_err), 32'h0);
    cyc(1'b1, 2'd2, 4'hE, 1'b1);
    cyc(1'b1, 2'd3, 4'hF, 1'b1);
    check("t3b_frame", 32'(frame_out), 32'hFEDC);
    check("t3b_valid", 32'(frame_valid), 32'h1);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    check("t3b_valid_drop", 32'(frame_valid), 32'h0);

    // Back-pressure: hold first frame, drop the next two
    send_frame(4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    send_frame(4'h2, 4'h2, 4'h2, 4'h2, 1'b0);
    send_frame(4'h3, 4'h3, 4'h3, 4'h3, 1'b0);
    check("t4_held_frame", 32'(frame_out), 32'h1111);
    check("t4_held_valid", 32'(frame_valid), 32'h1);
    check("t4_drop", 32'(drop_cnt), 32'd2);
    cyc(1'b1, 2'd0, 4'h4, 1'b0);
    cyc(1'b1, 2'd1, 4'h4, 1'b0);
    cyc(1'b1, 2'd2, 4'h4, 1'b0);
    cyc(1'b1, 2'd3, 4'h4, 1'b1);
    check("t4_reload_frame", 32'(frame_out), 32'h4444);
    check("t4_reload_valid", 32'(frame_valid), 32'h1);
    check("t4_reload_drop", 32'(drop_cnt), 32'd2);
    cyc(1'b0, 2'd0, 4'h0, 1'b1);
    check("t4_valid_drop", 32'(frame_valid), 32'h0);

    // 300 frames with no ready: first loads, rest drop until saturation
    send_frame(4'h7, 4'h7, 4'h7, 4'h7, 1'b0);
    for (int i = 0; i < 100; i++) send_frame(4'h5, 4'h5, 4'h5, 4'h5, 1'b0);
    check("t5_drop_mid", 32'(drop_cnt), 32'd102);
    for (int i = 0; i < 199; i++) send_frame(4'h6, 4'h6, 4'h6, 4'h6, 1'b0);
    check("t5_drop_sat", 32'(drop_cnt), 32'd255);
    check("t5_held_frame", 32'(frame_out), 32'h7777);

    // Asynchronous reset mid-frame with a pending frame
    cyc(1'b1, 2'd0, 4'h3, 1'b0);
    cyc(1'b1, 2'd1, 4'h3, 1'b0);
    strobe_in = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_frame", 32'(frame_out), 32'h0);
    check("t6_async_valid", 32'(frame_valid), 32'h0);
    check("t6_async_drop", 32'(drop_cnt), 32'h0);
    check("t6_async_seq_err", 32'(seq_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b1, 2'd1, 4'h3, 1'b1);
    check("t6_sync_ign", 32'(seq_err), 32'h0);
    send_frame(4'h9, 4'hA, 4'hB, 4'hC, 1'b1);
    check("t6_frame", 32'(frame_out), 32'hCBA9);
    check("t6_valid", 32'(frame_valid), 32'h1);
    check("t6_drop", 32'(drop_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_frame_capture.md
# scan_frame_capture

- Receive end of the multiplexed digit stream that the high-speed scan counter drives: sees a 2-bit select plus the digit currently on the shared bus.
- Rebuilds the 4-digit frame, checks that selects arrive in scan order 0→1→2→3→0, and presents complete frames on a valid/ready output.
- Sits between the multiplexed error/digit bus and the consumer (display latch, checker or logger).
- Reports sequence errors and frames dropped due to back-pressure.

## Interface
Parameters:
- DIGIT_W, 4, width of one digit on the multiplexed bus

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- strobe_in  in  1  sel_in/digit_in valid this cycle
- sel_in  in  2  digit index currently selected by the scanner
- digit_in  in  DIGIT_W  digit value for sel_in
- frame_ready  in  1  consumer accepts frame_out this cycle
- frame_out  out  4*DIGIT_W  captured frame; digit k at bits [k*DIGIT_W +: DIGIT_W]
- frame_valid  out  1  frame_out holds an unaccepted frame
- seq_err  out  1  one-cycle pulse on an out-of-order select
- drop_cnt  out  8  frames discarded because the output slot was full; saturates at 255

## Operation
- Internal state: shadow register of 4 digits, 2-bit expected index `exp`, FSM with states SYNC and COLLECT.
- SYNC (reset state, exp=0):
  - Strobes with sel_in≠0 are ignored silently.
  - Strobe with sel_in=0 stores digit 0, sets exp=1 and enters COLLECT.
- COLLECT, strobe with sel_in==exp:
  - Store digit_in into shadow[sel_in].
  - exp increments, wrapping 3→0.
- COLLECT, strobe with sel_in==3 matching: frame complete.
  - Output slot free (frame_valid=0, or frame_valid=1 with frame_ready=1 this cycle): load frame_out from shadow with digit 3 taken from digit_in; frame_valid=1.
  - Otherwise: frame discarded, drop_cnt increments (saturating).
  - Either way stay in COLLECT with exp=0.
- COLLECT, strobe with sel_in≠exp:
  - seq_err=1 for one cycle and the partial frame is abandoned.
  - If sel_in=0: treat as the start of a new frame (store digit 0, exp=1, stay in COLLECT).
  - Else: go to SYNC.
- No strobe: no state change.
- Shadow digits are not cleared on error; they are overwritten by the next frame.
- frame_valid/frame_ready:
  - Transfer occurs on a rising edge with both high.
  - frame_out is stable while frame_valid=1 and frame_ready=0.
  - frame_valid drops the cycle after a transfer unless a new frame loads on the same edge.
- Reset (reset_n=0, any time, including mid-frame):
  - frame_out=0, frame_valid=0, seq_err=0, drop_cnt=0, shadow=0, exp=0, state SYNC.
  - A pending unaccepted frame is lost.

## Timing
- Latency: frame_valid and frame_out update on the edge that samples the strobe carrying sel_in=3, i.e. visible the cycle after that strobe.
- seq_err is registered: high in the cycle after the offending strobe, for exactly one cycle per offending strobe.
- Throughput: one frame per 4 strobes; consecutive-cycle strobes are supported with no bubbles.
- Simultaneous completion and frame_ready=1 with frame_valid=1: the old frame transfers, the new frame loads, and frame_valid stays 1 with no drop.
- drop_cnt updates on the edge of the dropping completion; at 255 it holds.
- reset_n asserts asynchronously; deassertion is synchronous to clk (external synchronizer). The first strobe is accepted on the first edge after deassertion.

## Test plan
- Reset, then strobes sel 0,1,2,3 with digits 1,2,3,4 on consecutive cycles, frame_ready=1 → frame_out=16'h4321 and frame_valid=1 for exactly one cycle, seq_err=0.
- Strobes sel 2,3,0,1,2,3 with digits A,B,1,2,3,4 → first two ignored (SYNC), no seq_err, frame_out=16'h4321.
- In COLLECT after sel 0,1, strobe sel 3 → seq_err pulse one cycle, state SYNC; next strobes 0..3 with 5,6,7,8 → frame_out=16'h8765.
- frame_ready=0, send three full frames → first frame is held unchanged, drop_cnt=2; then frame_ready=1 for one cycle coincident with a 4th completion → transfer plus reload, frame_valid stays 1, drop_cnt=2.
- Hold frame_ready=0 and send 300 frames → drop_cnt saturates at 255.
- Assert reset_n=0 after sel 0,1 mid-frame with frame_valid=1 → all outputs 0 immediately (asynchronous); after release, sel 1 is ignored and sel 0..3 yields a new frame.
